// File: rtl/otter_pkg.sv
// otter_pkg: shared types and constants for the OTTER fetch stage.
//   fetch_state_t : fetch FSM states
//   fetch_entry_t : one queued instruction word with its address
package otter_pkg;
    localparam int              ILEN         = 32;
    localparam logic [ILEN-1:0] RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {BOOT, FETCH, FLUSH} fetch_state_t;

    typedef struct packed {
        logic [ILEN-1:0] ir;
        logic [ILEN-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/otter_fetch_fifo.sv
// otter_fetch_fifo: small in-order queue with synchronous clear.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : empty the queue (wins over push/pop)
//   i_push, i_din  : write one entry
//   i_pop          : drop the head entry
//   o_dout         : head entry (storage resets to zero, so it reads 0 after reset)
//   o_count        : number of valid entries
module otter_fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
)(
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_clr,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [WIDTH-1:0]             i_din,
    output logic [WIDTH-1:0]             o_dout,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [PW-1:0]               r_wr;
    logic [PW-1:0]               r_rd;
    logic [CW-1:0]               r_count;

    // pointers wrap explicitly so non-power-of-two depths work
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem   <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_din;
                r_wr        <= ptr_inc(r_wr);
            end
            if (i_pop)
                r_rd <= ptr_inc(r_rd);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_dout  = r_mem[r_rd];
    assign o_count = r_count;
endmodule

// File: rtl/otter_fetch.sv
// otter_fetch: OTTER instruction fetch stage.
// Owns the PC, issues word reads over req/gnt/rvalid, queues returned words
// in order and hands them to decode with a valid/ready handshake.
//   i_clk, i_rst_n                : clock, async active-low reset
//   i_redirect_valid/_pc          : taken branch/jump/trap; flush and refetch
//   o_imem_req/_addr, i_imem_gnt  : read request channel
//   i_imem_rvalid/_rdata          : in-order read response channel
//   o_ir_valid, i_ir_ready        : decode handshake
//   o_ir, o_ir_pc, o_imm_field    : head instruction, its address, ir[31:7]
module otter_fetch
    import otter_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_VECTOR,
    parameter int          DEPTH    = 2
)(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_ir_valid,
    input  logic        i_ir_ready,
    output logic [31:0] o_ir,
    output logic [31:0] o_ir_pc,
    output logic [24:0] o_imm_field
);
    localparam int CW = $clog2(DEPTH+1);

    fetch_state_t r_state, w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  r_rsp_pc;     // address belonging to the next kept response
    logic [CW-1:0] r_out;       // granted, not yet returned
    logic [CW-1:0] r_drop;      // returned data still to be discarded
    logic         r_ir_valid;

    logic          w_redir, w_rv, w_pop, w_req, w_gnt;
    logic          w_push, w_fpop;
    logic [CW-1:0] w_count, w_out_nxt, w_cnt_nxt;
    logic [CW:0]   w_used, w_limit;
    fetch_entry_t  w_head;

    assign w_redir = i_redirect_valid && (r_state != BOOT);
    // an rvalid with nothing outstanding is illegal and ignored
    assign w_rv    = i_imem_rvalid && (r_out != '0);
    assign w_pop   = r_ir_valid && i_ir_ready;

    // Counting this cycle's pop lets a new request go out while the queue is
    // full-but-draining, which is what gives one instruction per cycle.
    assign w_used  = {1'b0, r_out} + {1'b0, w_count};
    assign w_limit = (CW+1)'(DEPTH) + (CW+1)'(w_pop);
    assign w_req   = (r_state == FETCH) && (w_used < w_limit);
    assign w_gnt   = w_req && i_imem_gnt;

    assign w_out_nxt = r_out + CW'(w_gnt) - CW'(w_rv);
    assign w_push    = w_rv && (r_state == FETCH) && !w_redir;
    assign w_fpop    = w_pop && !w_redir;
    assign w_cnt_nxt = w_count + CW'(w_push) - CW'(w_fpop);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BOOT:  w_state_nxt = FETCH;
            FETCH: if (w_redir) w_state_nxt = (w_out_nxt != '0) ? FLUSH : FETCH;
            FLUSH: begin
                if (w_redir)
                    w_state_nxt = (w_out_nxt != '0) ? FLUSH : FETCH;
                else if (w_rv && (r_drop == CW'(1)))
                    w_state_nxt = FETCH;
            end
            default: w_state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= BOOT;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc       <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_out      <= '0;
            r_drop     <= '0;
            r_ir_valid <= 1'b0;
        end else begin
            r_out <= w_out_nxt;
            if (w_redir) begin
                // everything in flight, including a same-cycle grant, is stale
                r_pc       <= i_redirect_pc & ~32'h3;
                r_rsp_pc   <= i_redirect_pc & ~32'h3;
                r_drop     <= w_out_nxt;
                r_ir_valid <= 1'b0;
            end else begin
                if (w_gnt)  r_pc     <= r_pc + 32'd4;
                if (w_push) r_rsp_pc <= r_rsp_pc + 32'd4;
                if ((r_state == FLUSH) && w_rv) r_drop <= r_drop - 1'b1;
                r_ir_valid <= (w_cnt_nxt != '0);
            end
        end
    end

    otter_fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_redir),
        .i_push  (w_push),
        .i_pop   (w_fpop),
        .i_din   ({i_imem_rdata, r_rsp_pc}),
        .o_dout  (w_head),
        .o_count (w_count)
    );

    assign o_imem_req  = w_req;
    assign o_imem_addr = r_pc;
    assign o_ir_valid  = r_ir_valid;
    assign o_ir        = w_head.ir;
    assign o_ir_pc     = w_head.pc;
    assign o_imm_field = w_head.ir[31:7];

    a_rvalid_outstanding: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_imem_rvalid && (r_out == '0)));
endmodule

// File: tb/tb_otter_fetch.sv
module tb_otter_fetch;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        i_rst_n, i_redirect_valid, i_imem_gnt, i_imem_rvalid, i_ir_ready;
    logic [31:0] i_redirect_pc, i_imem_rdata;
    logic        o_imem_req, o_ir_valid;
    logic [31:0] o_imem_addr, o_ir, o_ir_pc;
    logic [24:0] o_imm_field;

    always #5 clk = ~clk;

    otter_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n),
        .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
        .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
        .o_ir_valid(o_ir_valid), .i_ir_ready(i_ir_ready),
        .o_ir(o_ir), .o_ir_pc(o_ir_pc), .o_imm_field(o_imm_field)
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] ir; logic [31:0] pc; } exp_t;

    mreq_t       mem_q[$];
    exp_t        exp_q[$];
    logic [31:0] gnt_log[$];
    logic [31:0] pop_log[$];
    logic [24:0] imm_log[$];
    int          pop_cyc[$];

    int          checks = 0, errors = 0, cyc = 0, lat = 1;
    bit          gnt_en = 1'b1, redir_now = 1'b0;
    logic [31:0] redir_target = '0, model_pc = RESET_PC;
    bit          p_hold = 0, p_stall = 0, last_req = 0, last_valid = 0;
    logic [31:0] p_addr, p_ir, p_irpc, last_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0000_0010) ? 32'hFFF0_0093 : (a ^ 32'h1357_9BDF);
    endfunction

    // One clock: drive memory/redirect inputs at negedge, observe, then advance.
    task automatic tick();
        bit do_rv, granted;
        exp_t e;
        do_rv = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        i_imem_rvalid    = do_rv;
        i_imem_rdata     = do_rv ? mem_word(mem_q[0].addr) : 32'hDEAD_BEEF;
        i_imem_gnt       = gnt_en;
        i_redirect_valid = redir_now;
        i_redirect_pc    = redir_target;
        #1;
        if (p_hold) begin
            checks++;
            if (o_imem_req !== 1'b1 || o_imem_addr !== p_addr) begin
                errors++;
                $display("FAIL req_hold: req=%0b addr=%h, required req=1 addr=%h", o_imem_req, o_imem_addr, p_addr);
            end
        end
        if (p_stall) begin
            checks++;
            if (o_ir_valid !== 1'b1 || o_ir !== p_ir || o_ir_pc !== p_irpc) begin
                errors++;
                $display("FAIL ir_hold: valid=%0b ir=%h pc=%h, required 1 %h %h", o_ir_valid, o_ir, o_ir_pc, p_ir, p_irpc);
            end
        end
        granted = o_imem_req && gnt_en;
        if (granted) begin
            checks++;
            if (o_imem_addr !== model_pc) begin
                errors++;
                $display("FAIL gnt_addr: addr=%h, required %h", o_imem_addr, model_pc);
            end
            gnt_log.push_back(o_imem_addr);
        end
        if (o_ir_valid && i_ir_ready && !redir_now) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: ir_pc=%h, required no valid instruction", o_ir_pc);
            end else begin
                e = exp_q.pop_front();
                if (o_ir !== e.ir || o_ir_pc !== e.pc || o_imm_field !== e.ir[31:7]) begin
                    errors++;
                    $display("FAIL pop_data: ir=%h pc=%h imm=%h, required %h %h %h",
                             o_ir, o_ir_pc, o_imm_field, e.ir, e.pc, e.ir[31:7]);
                end
            end
            pop_log.push_back(o_ir_pc);
            imm_log.push_back(o_imm_field);
            pop_cyc.push_back(cyc);
        end
        if (do_rv) void'(mem_q.pop_front());
        if (granted) mem_q.push_back('{o_imem_addr, cyc + lat});
        if (redir_now) begin
            exp_q.delete();
            model_pc = redir_target & ~32'h3;
        end else if (granted) begin
            exp_q.push_back('{mem_word(model_pc), model_pc});
            model_pc = model_pc + 32'd4;
        end
        last_req   = o_imem_req;
        last_valid = o_ir_valid;
        last_addr  = o_imem_addr;
        p_hold     = o_imem_req && !gnt_en && !redir_now;
        p_stall    = o_ir_valid && !i_ir_ready && !redir_now;
        p_addr     = o_imem_addr;
        p_ir       = o_ir;
        p_irpc     = o_ir_pc;
        redir_now  = 1'b0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic reset_dut();
        i_rst_n = 1'b0; i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0;
        i_redirect_valid = 1'b0; redir_now = 1'b0;
        mem_q.delete(); exp_q.delete();
        model_pc = RESET_PC; p_hold = 0; p_stall = 0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        i_rst_n = 1'b1;
    endtask

    task automatic clear_logs();
        gnt_log.delete(); pop_log.delete(); imm_log.delete(); pop_cyc.delete();
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_imem_req !== 1'b0 || o_ir_valid !== 1'b0 || o_ir !== 32'h0 || o_ir_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_vals: req=%0b valid=%0b ir=%h pc=%h, required 0 0 0 0", o_imem_req, o_ir_valid, o_ir, o_ir_pc);
        end
        reset_dut();
        #1;
        checks++;
        if (o_imem_req !== 1'b0) begin
            errors++;
            $display("FAIL boot_req: req=%0b, required 0", o_imem_req);
        end
        @(negedge clk);
        cyc++;
        checks++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL first_fetch: req=%0b addr=%h, required 1 %h", o_imem_req, o_imem_addr, RESET_PC);
        end
        reset_dut();
    endtask

    task automatic test_stream();
        bit req_seen[$];
        reset_dut();
        lat = 1; gnt_en = 1; i_ir_ready = 1'b1;
        clear_logs();
        for (int i = 0; i < 10; i++) begin
            tick();
            req_seen.push_back(last_req);
        end
        checks++;
        if (req_seen[0] !== 1'b0) begin
            errors++;
            $display("FAIL boot_req_stream: req=%0b, required 0", req_seen[0]);
        end
        for (int i = 1; i < 10; i++) begin
            checks++;
            if (req_seen[i] !== 1'b1) begin
                errors++;
                $display("FAIL stream_req[%0d]: req=%0b, required 1", i, req_seen[i]);
            end
        end
        checks++;
        if (pop_log.size() < 4) begin
            errors++;
            $display("FAIL stream_count: pops=%0d, required >=4", pop_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (pop_log[i] !== 32'(4*i) || pop_cyc[i] != pop_cyc[0] + i) begin
                    errors++;
                    $display("FAIL stream_seq[%0d]: pc=%h cyc=%0d, required pc=%h cyc=%0d",
                             i, pop_log[i], pop_cyc[i], 32'(4*i), pop_cyc[0] + i);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int guard;
        reset_dut();
        lat = 1; gnt_en = 1; i_ir_ready = 1'b0;
        tick();
        clear_logs();
        repeat (8) tick();
        checks++;
        if (gnt_log.size() < 1 || gnt_log.size() > DEPTH || last_req !== 1'b0) begin
            errors++;
            $display("FAIL stall_grants: grants=%0d req=%0b, required 1..%0d and req=0", gnt_log.size(), last_req, DEPTH);
        end
        i_ir_ready = 1'b1;
        guard = 0;
        while (pop_log.size() < 6 && guard < 40) begin tick(); guard++; end
        checks++;
        if (pop_log.size() < 6) begin
            errors++;
            $display("FAIL drain_timeout: pops=%0d, required 6", pop_log.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (pop_log[i] !== 32'(4*i)) begin
                    errors++;
                    $display("FAIL drain_order[%0d]: pc=%h, required %h", i, pop_log[i], 32'(4*i));
                end
            end
        end
    endtask

    task automatic test_redirect_flush();
        int guard;
        reset_dut();
        lat = 4; gnt_en = 1; i_ir_ready = 1'b1;
        guard = 0;
        while (mem_q.size() < 2 && guard < 10) begin tick(); guard++; end
        checks++;
        if (mem_q.size() != 2) begin
            errors++;
            $display("FAIL inflight_setup: inflight=%0d, required 2", mem_q.size());
        end
        redir_now = 1'b1; redir_target = 32'h0000_0100;
        tick();
        clear_logs();
        guard = 0;
        while (mem_q.size() > 0 && guard < 20) begin
            tick(); guard++;
            checks++;
            if (last_req !== 1'b0 || last_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_quiet: req=%0b valid=%0b, required 0 0", last_req, last_valid);
            end
        end
        guard = 0;
        while (pop_log.size() < 1 && guard < 20) begin tick(); guard++; end
        checks++;
        if (pop_log.size() < 1 || pop_log[0] !== 32'h100) begin
            errors++;
            $display("FAIL redirect_target: pops=%0d pc=%h, required pc 00000100", pop_log.size(),
                     (pop_log.size() > 0) ? pop_log[0] : 32'hX);
        end
    endtask

    task automatic test_gnt_stall();
        reset_dut();
        lat = 1; gnt_en = 0; i_ir_ready = 1'b1;
        tick();
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (last_req !== 1'b1 || last_addr !== RESET_PC) begin
                errors++;
                $display("FAIL gnt_wait[%0d]: req=%0b addr=%h, required 1 %h", i, last_req, last_addr, RESET_PC);
            end
        end
        gnt_en = 1;
        tick();
        tick();
        checks++;
        if (last_addr !== RESET_PC + 32'd4 || gnt_log.size() != 2) begin
            errors++;
            $display("FAIL pc_after_gnt: addr=%h grants=%0d, required %h 2", last_addr, gnt_log.size(), RESET_PC + 32'd4);
        end
        // gnt and rvalid coincide every cycle from here on
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (last_req !== 1'b1) begin
                errors++;
                $display("FAIL overlap_req[%0d]: req=%0b, required 1", i, last_req);
            end
        end
    endtask

    task automatic test_wrap_align();
        int guard;
        lat = 1; gnt_en = 1; i_ir_ready = 1'b1;
        redir_now = 1'b1; redir_target = 32'hFFFF_FFF8;
        tick();
        clear_logs();
        guard = 0;
        while (gnt_log.size() < 3 && guard < 20) begin tick(); guard++; end
        checks++;
        if (gnt_log.size() < 3 || gnt_log[0] !== 32'hFFFF_FFF8 || gnt_log[1] !== 32'hFFFF_FFFC || gnt_log[2] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_fetch: grants=%0d first=%h, required FFFFFFF8 FFFFFFFC 00000000", gnt_log.size(),
                     (gnt_log.size() > 0) ? gnt_log[0] : 32'hX);
        end
        redir_now = 1'b1; redir_target = 32'h0000_0203;
        tick();
        clear_logs();
        guard = 0;
        while (pop_log.size() < 1 && guard < 20) begin tick(); guard++; end
        checks++;
        if (gnt_log.size() < 1 || gnt_log[0] !== 32'h200 || pop_log.size() < 1 || pop_log[0] !== 32'h200) begin
            errors++;
            $display("FAIL align_redirect: grant=%h pop=%h, required 00000200 00000200",
                     (gnt_log.size() > 0) ? gnt_log[0] : 32'hX, (pop_log.size() > 0) ? pop_log[0] : 32'hX);
        end
    endtask

    task automatic test_reset_midstream();
        int guard;
        lat = 1; gnt_en = 1; i_ir_ready = 1'b0;
        repeat (4) tick();
        checks++;
        if (last_valid !== 1'b1) begin
            errors++;
            $display("FAIL queued_setup: valid=%0b, required 1", last_valid);
        end
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_ir_valid !== 1'b0 || o_imem_req !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%0b req=%0b, required 0 0", o_ir_valid, o_imem_req);
        end
        reset_dut();
        i_ir_ready = 1'b1;
        clear_logs();
        guard = 0;
        while (pop_log.size() < 5 && guard < 30) begin tick(); guard++; end
        checks++;
        if (pop_log.size() < 5 || pop_log[0] !== RESET_PC || pop_log[4] !== 32'h10 || imm_log[4] !== 25'h1FF_E001) begin
            errors++;
            $display("FAIL restart_imm: pops=%0d first=%h imm=%h, required first %h imm 1ffe001", pop_log.size(),
                     (pop_log.size() > 0) ? pop_log[0] : 32'hX, (imm_log.size() > 4) ? imm_log[4] : 25'hX, RESET_PC);
        end
    endtask

    initial begin
        i_rst_n = 1'b0; i_redirect_valid = 1'b0; i_redirect_pc = '0;
        i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = '0; i_ir_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_gnt_stall();
        test_wrap_align();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
